// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline-register stages (IF/ID, ID/EX, EX/MEM,
// MEM/WB):
//   stage_state_e  : stage occupancy state (EMPTY / HOLD / FULL)
//   occ_t          : held-entry count, 0..2
//   occ_of_state() : maps a stage state to its entry count
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no entry held
        ST_HOLD  = 2'd1,   // one entry, in the main register
        ST_FULL  = 2'd2    // two entries, main + skid
    } stage_state_e;

    typedef logic [1:0] occ_t;

    function automatic occ_t occ_of_state(input stage_state_e s);
        occ_t n;
        case (s)
            ST_EMPTY: n = 2'd0;
            ST_HOLD:  n = 2'd1;
            ST_FULL:  n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Valid/ready pipeline register between two CPU pipeline stages. Holds up to
// two entries (main + skid) when SKID=1 so that in_ready can be a registered
// signal; with SKID=0 it holds one entry and in_ready is combinational.
//
// Parameters
//   DATA_W    datapath payload width (PC+4, rs1, rs2, immediate)
//   CTRL_W    control payload width (flags, alu_op, register addresses)
//   SKID      1 = two-entry skid mode, 0 = single-entry mode
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   squash all held entries and the offered entry
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage accepts an entry this cycle
//   in_ctrl    in   [CTRL_W] control payload
//   in_data    in   [DATA_W] data payload
//   out_valid  out  head entry presented downstream
//   out_ready  in   downstream consumes the head entry
//   out_ctrl   out  [CTRL_W] head control, forced to zero (bubble) when empty
//   out_data   out  [DATA_W] head data, keeps its last value when empty
//   occupancy  out  [2] number of held entries
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 26,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_e      r_state;
    stage_state_e      w_state_next;
    occ_t              r_occ;

    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_out_valid;
    logic              w_accept;
    logic              w_consume;
    logic              w_load_main_in;    // main <= input
    logic              w_load_main_skid;  // main <= skid
    logic              w_load_skid;       // skid <= input

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_consume   = w_out_valid && out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_occ   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_occ   <= occ_of_state(w_state_next);
        end
    end

    // -------------------------------------------------------------------------
    // Next state and payload load enables
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            // Squash wins over accept and consume; payload registers keep
            // their contents, only the state forgets them.
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next   = ST_HOLD;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_consume && w_accept) begin
                        w_state_next   = ST_HOLD;
                        w_load_main_in = 1'b1;
                    end else if (w_consume) begin
                        w_state_next = ST_EMPTY;
                    end else if (w_accept && (SKID != 0)) begin
                        // Main is stalled: park the new entry in the skid.
                        w_state_next = ST_FULL;
                        w_load_skid  = 1'b1;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can happen.
                    if (w_consume) begin
                        w_state_next     = ST_HOLD;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Main (head) payload register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
        end
    end

    // -------------------------------------------------------------------------
    // Skid register and in_ready generation
    // -------------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              r_in_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            // Registered ready: looks only at where the state is going, so
            // there is no path from out_ready to in_ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != ST_FULL);
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
            assign in_ready    = r_in_ready;
        end else begin : g_noskid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
            // Accept whenever the single slot is free or draining this cycle.
            assign in_ready    = !w_out_valid || out_ready;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_occ;

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
// Scoreboard bench for pipe_stage_skid: SKID=1 instance (u_dut) driven through
// streaming, backpressure, flush, simultaneous and reset scenarios; SKID=0
// instance (u_dut0) driven through the single-entry ready behaviour.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 26;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic              flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // SKID=0 instance
    logic              s0_flush = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
    logic [CTRL_W-1:0] s0_in_ctrl = '0;
    logic [DATA_W-1:0] s0_in_data = '0;
    logic              s0_in_ready, s0_out_valid;
    logic [CTRL_W-1:0] s0_out_ctrl;
    logic [DATA_W-1:0] s0_out_data;
    logic [1:0]        s0_occupancy;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl), .out_data(s0_out_data),
        .occupancy(s0_occupancy)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    item_t exp_q[$];

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
        logic [CTRL_W-1:0] c;
        c = '0;
        c[7:0] = d[7:0];
        c[CTRL_W-1] = 1'b1;
        return c;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctrl_of(d);
    endtask

    task automatic drive0(input logic v, input logic [DATA_W-1:0] d);
        s0_in_valid = v;
        s0_in_data  = d;
        s0_in_ctrl  = ctrl_of(d);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        item_t it;
        it.data = d;
        it.ctrl = ctrl_of(d);
        exp_q.push_back(it);
    endtask

    // Monitor: every consume edge of u_dut pops and compares one entry.
    always @(negedge clk) begin
        item_t e;
        if (!rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_entry: got data %0h, required no entry", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_ctrl", DATA_W'(out_ctrl), DATA_W'(e.ctrl));
                $display("consume data=%0h ctrl=%0h", out_data, out_ctrl);
            end
        end
    end

    // Single-entry build must never report more than one held entry.
    always @(negedge clk) begin
        if (!rst) chk("s0_occ_max", DATA_W'(s0_occupancy <= 2'd1), 1);
    end

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DATA_W'(out_valid), 0);
        chk("rst_out_ctrl",  DATA_W'(out_ctrl), 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_occupancy", DATA_W'(occupancy), 0);
        chk("rst_in_ready",  DATA_W'(in_ready), 1);
        chk("s0_rst_in_ready", DATA_W'(s0_in_ready), 1);
        rst = 1'b0;

        // ---------------- streaming 1..8 ----------------
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, DATA_W'(k + 1));
            push(DATA_W'(k + 1));
            @(negedge clk);
            chk("stream_in_ready", DATA_W'(in_ready), 1);
            if (k == 0) begin
                chk("stream_latency_valid", DATA_W'(out_valid), 0);
            end else begin
                chk("stream_valid", DATA_W'(out_valid), 1);
                chk("stream_data", out_data, DATA_W'(k));
                chk("stream_occ", DATA_W'(occupancy), 1);
            end
            tick();
        end
        drive(1'b0, '0);
        @(negedge clk);
        chk("stream_last_data", out_data, 8);
        tick();
        @(negedge clk);
        chk("stream_drained_valid", DATA_W'(out_valid), 0);
        chk("stream_drained_occ", DATA_W'(occupancy), 0);
        tick();

        // ---------------- backpressure A, B, C ----------------
        out_ready = 1'b0;
        drive(1'b1, 'hA); push('hA);
        @(negedge clk);
        chk("bp_ready0", DATA_W'(in_ready), 1);
        chk("bp_occ0", DATA_W'(occupancy), 0);
        tick();
        drive(1'b1, 'hB); push('hB);
        @(negedge clk);
        chk("bp_ready1", DATA_W'(in_ready), 1);
        chk("bp_occ1", DATA_W'(occupancy), 1);
        tick();
        drive(1'b1, 'hC); push('hC);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("bp_full_occ", DATA_W'(occupancy), 2);
            chk("bp_full_ready", DATA_W'(in_ready), 0);
            chk("bp_full_head", out_data, 'hA);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_ready", DATA_W'(in_ready), 0);
        tick();
        @(negedge clk);
        chk("bp_hold_ready", DATA_W'(in_ready), 1);
        chk("bp_hold_occ", DATA_W'(occupancy), 1);
        tick();
        drive(1'b0, '0);
        @(negedge clk);
        chk("bp_c_occ", DATA_W'(occupancy), 1);
        tick();
        @(negedge clk);
        chk("bp_empty_occ", DATA_W'(occupancy), 0);
        chk("bp_empty_valid", DATA_W'(out_valid), 0);
        tick();

        // ---------------- simultaneous accept + consume in HOLD ----------------
        out_ready = 1'b1;
        drive(1'b1, 'h21); push('h21);
        @(negedge clk);
        tick();
        drive(1'b1, 'h22); push('h22);
        @(negedge clk);
        chk("sim_hold_occ", DATA_W'(occupancy), 1);
        tick();
        drive(1'b0, '0);
        @(negedge clk);
        chk("sim_next_occ", DATA_W'(occupancy), 1);
        chk("sim_next_data", out_data, 'h22);
        tick();
        @(negedge clk);
        chk("sim_empty_occ", DATA_W'(occupancy), 0);
        tick();

        // ---------------- flush with occupancy 2 ----------------
        out_ready = 1'b0;
        drive(1'b1, 'hE);
        tick();
        drive(1'b1, 'hF);
        tick();
        drive(1'b1, 'hD);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_occ", DATA_W'(occupancy), 2);
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        @(negedge clk);
        chk("flush_occ", DATA_W'(occupancy), 0);
        chk("flush_valid", DATA_W'(out_valid), 0);
        chk("flush_ctrl", DATA_W'(out_ctrl), 0);
        chk("flush_ready", DATA_W'(in_ready), 1);
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            @(negedge clk);
            chk("flush_stays_empty", DATA_W'(out_valid), 0);
        end
        tick();

        // ---------------- asynchronous reset with occupancy 2 ----------------
        out_ready = 1'b0;
        drive(1'b1, 'h31);
        tick();
        drive(1'b1, 'h32);
        tick();
        drive(1'b0, '0);
        @(negedge clk);
        chk("arst_pre_occ", DATA_W'(occupancy), 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", DATA_W'(out_valid), 0);
        chk("arst_out_ctrl", DATA_W'(out_ctrl), 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_occ", DATA_W'(occupancy), 0);
        chk("arst_in_ready", DATA_W'(in_ready), 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 'h33); push('h33);
        @(negedge clk);
        chk("arst_latency_valid", DATA_W'(out_valid), 0);
        tick();
        drive(1'b0, '0);
        @(negedge clk);
        chk("arst_first_valid", DATA_W'(out_valid), 1);
        chk("arst_first_occ", DATA_W'(occupancy), 1);
        tick();
        @(negedge clk);
        chk("arst_drained_occ", DATA_W'(occupancy), 0);
        tick();

        // ---------------- SKID=0 build ----------------
        s0_out_ready = 1'b0;
        drive0(1'b1, 'h41);
        @(negedge clk);
        chk("s0_ready_empty", DATA_W'(s0_in_ready), 1);
        tick();
        drive0(1'b1, 'h42);
        chk("s0_ready_blocked", DATA_W'(s0_in_ready), 0);
        chk("s0_occ_hold", DATA_W'(s0_occupancy), 1);
        chk("s0_head", s0_out_data, 'h41);
        s0_out_ready = 1'b1;
        #1;
        chk("s0_ready_comb", DATA_W'(s0_in_ready), 1);
        @(negedge clk);
        tick();
        drive0(1'b0, '0);
        chk("s0_next_data", s0_out_data, 'h42);
        chk("s0_next_ctrl", DATA_W'(s0_out_ctrl), DATA_W'(ctrl_of('h42)));
        chk("s0_next_occ", DATA_W'(s0_occupancy), 1);
        tick();
        @(negedge clk);
        chk("s0_empty_valid", DATA_W'(s0_out_valid), 0);
        chk("s0_empty_occ", DATA_W'(s0_occupancy), 0);
        tick();

        chk("queue_empty", DATA_W'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_stage_skid

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 128: width of the datapath payload (PC+4, rs1, rs2, immediate).
REQ-002 Parameter CTRL_W, default 26: width of the control payload (write/mem/branch flags, alu_op, rd/rs1/rs2 addresses).
REQ-003 Parameter SKID, default 1: 1 = two-entry skid mode with registered in_ready; 0 = single-entry mode with combinational in_ready.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset: asynchronous, active-high.
REQ-006 flush  input  1  synchronous squash of all held entries (hazard/branch redirect).
REQ-007 in_valid  input  1  upstream offers an entry.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  control payload.
REQ-010 in_data  input  DATA_W  data payload.
REQ-011 out_valid  output  1  head entry presented downstream.
REQ-012 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-013 out_ctrl  output  CTRL_W  head control payload; all-zero (bubble) whenever out_valid=0.
REQ-014 out_data  output  DATA_W  head data payload; holds its last value when out_valid=0.
REQ-015 occupancy  output  2  number of held entries, 0..2 (0..1 when SKID=0).

Function
REQ-016 An entry SHALL be accepted on an edge where in_valid && in_ready && !flush, and consumed on an edge where out_valid && out_ready.
REQ-017 The state machine SHALL have states EMPTY (0 entries), HOLD (1 entry, main register) and FULL (2 entries, main + skid; SKID=1 only).
REQ-018 Transitions: EMPTY to HOLD on accept; HOLD to EMPTY on consume without accept; HOLD to HOLD on consume with accept (main reloaded); HOLD to FULL on accept without consume (entry written to skid); FULL to HOLD on consume (skid moved to main).
REQ-019 In FULL, in_ready SHALL be 0 and no accept SHALL occur.
REQ-020 For SKID=1, in_ready SHALL be a registered value equal to (next state != FULL), with no combinational path from out_ready.
REQ-021 For SKID=0, in_ready SHALL equal !out_valid || out_ready combinationally, and FULL SHALL be unreachable.
REQ-022 Latency SHALL be exactly one cycle from accept to out_valid when the stage is EMPTY, and throughput SHALL be one entry per cycle while out_ready=1.
REQ-023 Entries SHALL leave in strict acceptance order; no entry is duplicated or dropped except by flush.
REQ-024 flush SHALL take priority over accept and consume on the same edge: next state is EMPTY, occupancy is 0, and the offered input is discarded.
REQ-025 After a flush edge, out_valid=0 and out_ctrl=0 SHALL hold from the next cycle on, and in_ready SHALL be 1.
REQ-026 occupancy SHALL be registered and equal to the entry count of the current state.
REQ-027 Payload registers SHALL load only on accept or on a skid-to-main move, with no enable-free loading.

Reset
REQ-028 While rst=1, the block SHALL be in state EMPTY with out_valid=0, out_ctrl=0, out_data=0, occupancy=0 and in_ready=1, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all held entries immediately; the first accept after rst deasserts behaves as accept from EMPTY.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enum (EMPTY/HOLD/FULL) and the occupancy type, for reuse by the IF/ID, EX/MEM and MEM/WB stages.
REQ-031 The block SHALL be a single module with no sub-module; SKID=0 removes the skid registers by generate.

Verification
REQ-032 Reset: rst=1 mid-stream with occupancy=2 -> same cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
REQ-033 Streaming: out_ready=1, send in_data=1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, one cycle later, no gaps.
REQ-034 Backpressure: send 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0; 0xC is held off; out_ready=1 -> 0xA, 0xB, 0xC in order.
REQ-035 Flush: occupancy=2, then flush=1 with in_valid=1 and in_data=0xD -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0xD never appears.
REQ-036 Simultaneous events: HOLD with out_ready=1 and in_valid=1 -> stays in HOLD, new entry on out_data next cycle, occupancy stays 1.
REQ-037 SKID=0 build: out_ready=0 while holding an entry -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally; occupancy never exceeds 1.
